// File: rtl/interfaz_alu_pkg.sv
// interfaz_alu_pkg: shared constants for the UART <-> ALU sequencer.
//   - FSM state encodings (3-bit), kept as localparams for legacy tools.
//   - ALU opcode constants, shared with the ALU and the benches.
//   - is_busy_state(): decodes the states in which the sequencer is busy.
package interfaz_alu_pkg;

    localparam logic [2:0] ST_WAIT_A  = 3'd0;
    localparam logic [2:0] ST_WAIT_B  = 3'd1;
    localparam logic [2:0] ST_WAIT_OP = 3'd2;
    localparam logic [2:0] ST_CALC    = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_WAIT_TX = 3'd5;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == ST_CALC) || (st == ST_SEND) || (st == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/interfaz_alu_if.sv
// interfaz_alu_if: bundles the UART receive/transmit handshakes and the ALU
// operand/result bus seen by interfaz_alu.
//   slave  modport: the sequencer (receives rx_*, alu_result, tx_done;
//                   drives dato_*, tx_start, tx_data, busy).
//   master modport: the surrounding UART/ALU side (opposite directions).
// Parameter nbits: operand/result and UART data width (must be >= 6).
interface interfaz_alu_if #(
    parameter int nbits = 8
);
    logic                    rx_done;
    logic        [nbits-1:0] rx_data;
    logic signed [nbits-1:0] alu_result;
    logic                    tx_done;
    logic signed [nbits-1:0] dato_A;
    logic signed [nbits-1:0] dato_B;
    logic        [5:0]       dato_Op;
    logic                    tx_start;
    logic        [nbits-1:0] tx_data;
    logic                    busy;

    modport slave (
        input  rx_done, rx_data, alu_result, tx_done,
        output dato_A, dato_B, dato_Op, tx_start, tx_data, busy
    );

    modport master (
        output rx_done, rx_data, alu_result, tx_done,
        input  dato_A, dato_B, dato_Op, tx_start, tx_data, busy
    );
endinterface

// File: rtl/contador_timeout.sv
// contador_timeout: inter-byte timeout counter.
//   clk, reset : clock, synchronous active-high reset.
//   clr        : clears the count (an accepted byte).
//   en         : count while high; the count is held at zero while low.
//   expired    : high while the count equals TIMEOUT_CYCLES-1.
// Parameter TIMEOUT_CYCLES: cycles of silence before expiry (>= 2).
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    assign expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr || !en || expired) begin
            // The expiry cycle clears too, so the counter never wraps.
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/interfaz_alu.sv
// interfaz_alu: sequencer between the UART receiver/transmitter and the ALU.
// Collects operand A, operand B and opcode bytes, holds them on the ALU
// inputs, registers the ALU result and requests its transmission.
//   clk, reset : clock, synchronous active-high reset.
//   bus.slave  : rx_done/rx_data in, alu_result in, tx_done in,
//                dato_A/dato_B/dato_Op out, tx_start/tx_data out, busy out.
// Parameters: nbits (data width, >= 6, must match the interface),
//             TIMEOUT_CYCLES (inter-byte timeout).
// Optional feature: define INTERFAZ_TIMEOUT_EN to abandon a partial triple
// after TIMEOUT_CYCLES cycles without a byte in WAIT_B/WAIT_OP.
module interfaz_alu
    import interfaz_alu_pkg::*;
#(
    parameter int nbits          = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          reset,
    interfaz_alu_if.slave bus
);
    logic [2:0]              state_q, state_d;
    logic signed [nbits-1:0] dato_a_q, dato_b_q;
    logic [5:0]              dato_op_q;
    logic [nbits-1:0]        tx_data_q;
    logic                    tx_start_q;
    logic                    expired;

`ifdef INTERFAZ_TIMEOUT_EN
    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (bus.rx_done),
        .en      ((state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP)),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expired        = 1'b0;
`endif

    // rx_done always wins over an expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A:  if (bus.rx_done) state_d = ST_WAIT_B;
            ST_WAIT_B: begin
                if (bus.rx_done)  state_d = ST_WAIT_OP;
                else if (expired) state_d = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (bus.rx_done)  state_d = ST_CALC;
                else if (expired) state_d = ST_WAIT_A;
            end
            ST_CALC:    state_d = ST_SEND;
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: if (bus.tx_done) state_d = ST_WAIT_A;
            default:    state_d = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_WAIT_A;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            dato_op_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // High exactly for the SEND cycle.
            tx_start_q <= (state_q == ST_CALC);
            if (bus.rx_done && (state_q == ST_WAIT_A))  dato_a_q  <= bus.rx_data;
            if (bus.rx_done && (state_q == ST_WAIT_B))  dato_b_q  <= bus.rx_data;
            if (bus.rx_done && (state_q == ST_WAIT_OP)) dato_op_q <= bus.rx_data[5:0];
            if (state_q == ST_CALC)                     tx_data_q <= bus.alu_result;
        end
    end

    assign bus.dato_A   = dato_a_q;
    assign bus.dato_B   = dato_b_q;
    assign bus.dato_Op  = dato_op_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = is_busy_state(state_q);
endmodule

// File: doc/interfaz_alu.md
# interfaz_alu

Sequencer between the UART receiver/transmitter and the combinational ALU. Collects three received bytes in order (operand A, operand B, opcode), holds them stable on the ALU inputs, captures the ALU result one cycle later and hands it to the UART transmitter with a start/done handshake. It sits directly upstream of the ALU for operands and opcode, and directly downstream of it for the result.

## Interface
- `nbits`, 8: operand/result width. Also the UART data width. Must be ≥ 6.
- `TIMEOUT_CYCLES`, 50_000_000: inter-byte timeout in clock cycles. Used only when `INTERFAZ_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: single clock. All state is updated on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `rx_done`  in  1: one-cycle pulse; a received byte is valid on `rx_data`.
- `rx_data`  in  nbits: received byte.
- `alu_result`  in  nbits signed: ALU result output (combinational from `dato_A`/`dato_B`/`dato_Op`).
- `tx_done`  in  1: one-cycle pulse; the transmitter has finished the byte.
- `dato_A`  out  nbits signed: operand A to the ALU.
- `dato_B`  out  nbits signed: operand B to the ALU.
- `dato_Op`  out  6: opcode to the ALU.
- `tx_start`  out  1: one-cycle request to transmit `tx_data`.
- `tx_data`  out  nbits: result byte to the transmitter.
- `busy`  out  1: high in CALC, SEND and WAIT_TX.

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX. Reset state is WAIT_A.
- WAIT_A: on `rx_done`, `dato_A` ← `rx_data`, then go to WAIT_B.
- WAIT_B: on `rx_done`, `dato_B` ← `rx_data`, then go to WAIT_OP.
- WAIT_OP: on `rx_done`, `dato_Op` ← `rx_data[5:0]` (upper bits discarded), then go to CALC.
- CALC: unconditional, one cycle. `tx_data` ← `alu_result`, then go to SEND.
- SEND: `tx_start` = 1 for exactly this cycle, then go to WAIT_TX.
- WAIT_TX: on `tx_done`, go to WAIT_A.
- `rx_done` in CALC, SEND or WAIT_TX is ignored and the byte is dropped.
- `tx_done` outside WAIT_TX is ignored.
- If `rx_done` and `tx_done` arrive in the same cycle in WAIT_TX: `tx_done` is honoured and `rx_done` is dropped.
- `dato_A`, `dato_B` and `dato_Op` hold their values until overwritten. They are not cleared after a transaction.
- The block does no arithmetic. `tx_data` is a bit-exact copy of `alu_result`.

## Timing
- Reset values: `dato_A`=0, `dato_B`=0, `dato_Op`=0, `tx_start`=0, `tx_data`=0, `busy`=0, state WAIT_A. This applies on any `reset`-high edge, including mid-transaction; a partially received triple is discarded.
- Opcode `rx_done` at edge k: `dato_Op` is valid after k and state is CALC; `busy` is high from k.
- `tx_data` is registered at edge k+1.
- `tx_start` is high for the cycle between edges k+1 and k+2.
- Minimum latency from opcode `rx_done` to `tx_start`: 2 cycles.
- `tx_done` at edge m returns the state to WAIT_A and drops `busy` after m. A new A byte is accepted from edge m+1.
- `tx_start` is a registered output, never combinational from inputs.

## Configuration
- `INTERFAZ_TIMEOUT_EN` defined:
  - A counter runs in WAIT_B and WAIT_OP and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`-1 without `rx_done`, the state returns to WAIT_A and the partial triple is dropped.
  - `dato_*` keep their last values.
  - If `rx_done` occurs in the expiry cycle, the byte is accepted and no timeout occurs.
  - The counter is cleared by reset.
- `INTERFAZ_TIMEOUT_EN` undefined: no counter; the block waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package / include holds:
  - state encodings (3-bit localparams);
  - ALU opcode constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111), also used by the ALU and the benches.
- One sub-module, `contador_timeout` (parameter `TIMEOUT_CYCLES`; ports `clk`, `reset`, `clr`, `en`, `expired`), instantiated only under `INTERFAZ_TIMEOUT_EN`.
- The FSM is a single registered-state process; the next-state logic and the datapath registers are in the same module.

## Test plan
- The bench closes the loop through the team's ALU and models the UART with pulse drivers.
- Bytes 0x05, 0x03, 0x20 → `dato_Op`=0x20; `tx_start` 2 cycles after the third `rx_done`; `tx_data`=0x08; `busy` high until `tx_done`.
- Bytes 0x03, 0x05, 0xE2 → `dato_Op`=0x22 (upper bits dropped); `tx_data`=0xFE.
- `rx_done` with 0x77 in CALC, SEND and WAIT_TX, plus `rx_done` in the same cycle as `tx_done` → `dato_A` unchanged; the next A byte is accepted only in WAIT_A.
- `reset` asserted in WAIT_OP after A=0x10 and B=0x20 → all outputs 0 next cycle; a fresh 0x01, 0x01, 0x20 gives `tx_data`=0x02.
- Back-to-back transactions with `tx_done` 10 cycles after `tx_start`, A sent the cycle after `tx_done` → both results correct; exactly one `tx_start` per triple.
- With `INTERFAZ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: A=0x09, then silence for 16 cycles → state WAIT_A. A following 0x02, 0x03, 0x24 gives `tx_data`=0x02; `rx_done` on the expiry cycle is accepted.
